// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage iterative multiplier.
//   state_t           : sequencer states (IDLE/RUN/DONE)
//   MUL_* constants   : RV32M `mul` encoding fields for the decoder and hazard unit
//   is_mul()          : decode helper returning 1 for a `mul` instruction word
package mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] MUL_OPCODE = 7'b0110011;
  localparam logic [2:0] MUL_FUNCT3 = 3'b000;
  localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;

  function automatic logic is_mul(input logic [31:0] instr);
    return (instr[6:0] == MUL_OPCODE) &&
           (instr[14:12] == MUL_FUNCT3) &&
           (instr[31:25] == MUL_FUNCT7);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Handshake/data bundle between EX stage and the multiply sequencer.
//   start, flush          : EX -> sequencer (a `mul` in EX / kill in-flight op)
//   operand_a, operand_b  : forwarded EX operands (multiplicand, multiplier)
//   stall, busy           : sequencer -> hazard unit / status
//   result, result_valid  : sequencer -> EX result mux
// master = EX-stage side, slave = sequencer.
interface mult_seq_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              flush;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              stall;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_valid;

  modport master (
    output start, flush, operand_a, operand_b,
    input  stall, busy, result, result_valid
  );

  modport slave (
    input  start, flush, operand_a, operand_b,
    output stall, busy, result, result_valid
  );
endinterface

// File: rtl/mult_seq_ctrl_step.sv
// mult_step: one partial-product accumulate step, purely combinational.
//   acc      : running accumulator
//   a        : multiplicand
//   b_chunk  : STEP_W-bit slice of the multiplier for this step
//   shift    : bit position of that slice within the multiplier
//   next_acc : acc + ((a * b_chunk) << shift), modulo 2^DATA_W
// Only the low DATA_W bits are kept throughout, which is all `mul` needs.
module mult_step #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STEP_W = 8,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] a,
  input  logic [STEP_W-1:0] b_chunk,
  input  logic [SH_W-1:0]   shift,
  output logic [DATA_W-1:0] next_acc
);
  logic [DATA_W-1:0] pp;

  always_comb begin
    pp       = a * DATA_W'(b_chunk);
    next_acc = acc + (pp << shift);
  end
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer for the EX-stage iterative multiplier (low 32 bits
// of RV32M `mul`). Operands are latched in IDLE, the product is built over
// STEPS RUN cycles (STEP_W multiplier bits each), and DONE presents a
// one-cycle result_valid pulse.
//   clk    : rising-edge clock
//   arst_n : asynchronous active-low reset
//   bus    : slave side of mult_seq_ctrl_if (start/flush/operands in,
//            stall/busy/result/result_valid out)
// DATA_W must be a multiple of STEP_W.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STEP_W = 8
) (
  input  logic            clk,
  input  logic            arst_n,
  mult_seq_ctrl_if.slave  bus
);
  localparam int unsigned STEPS = DATA_W / STEP_W;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned SH_W  = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] a_q, b_q, acc_q;
  logic [DATA_W-1:0] next_acc;
  logic [SH_W-1:0]   shift;
  logic [STEP_W-1:0] b_chunk;
  logic              accept;
  logic              last_step;

  // Bit offset of the current multiplier slice; selecting it with a right
  // shift avoids a variable-index part select.
  assign shift     = SH_W'(count_q) * SH_W'(STEP_W);
  assign b_chunk   = STEP_W'(b_q >> shift);
  assign last_step = (count_q == CNT_W'(STEPS - 1));
  assign accept    = (state_q == IDLE) && bus.start && !bus.flush;

  mult_step #(
    .DATA_W (DATA_W),
    .STEP_W (STEP_W),
    .SH_W   (SH_W)
  ) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .b_chunk  (b_chunk),
    .shift    (shift),
    .next_acc (next_acc)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.stall        = 1'b0;
    bus.busy         = (state_q == RUN);
    bus.result_valid = (state_q == DONE);
    bus.result       = acc_q;

    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last_step) state_d = DONE;
      // start in DONE is still the instruction that just finished
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      bus.stall = ((state_q == IDLE) && bus.start) || (state_q == RUN);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else if (bus.flush) begin
      count_q <= '0;
    end else if (accept) begin
      a_q     <= bus.operand_a;
      b_q     <= bus.operand_b;
      acc_q   <= '0;
      count_q <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= next_acc;
      count_q <= last_step ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STEPS  = 4;

  logic clk = 1'b0;
  logic arst_n;
  int   total = 0;
  int   bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.DATA_W(DATA_W)) bus();

  mult_seq_ctrl #(
    .DATA_W (DATA_W),
    .STEP_W (8)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every result_valid pulse must match the oldest pending product.
  always @(negedge clk) begin
    if (arst_n && bus.result_valid) begin
      if (exp_q.size() == 0) check("rv_unexpected", 32'd1, 32'd0);
      else check("result", bus.result, exp_q.pop_front());
    end
  end

  // Caller is in an IDLE cycle (#1 after an edge). Runs one multiply,
  // scrambling the operand inputs during RUN. keep=1 leaves start high after
  // DONE so the next multiply is accepted in the cycle right after DONE.
  task automatic run_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic keep);
    logic [63:0] full;
    full          = 64'(a) * 64'(b);
    bus.start     = 1'b1;
    bus.operand_a = a;
    bus.operand_b = b;
    exp_q.push_back(full[DATA_W-1:0]);
    #1;
    check("stall_accept", 32'(bus.stall), 32'd1);
    for (int i = 0; i < STEPS; i++) begin
      @(posedge clk); #1;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      #1;
      check("stall_run", 32'(bus.stall), 32'd1);
      check("busy_run", 32'(bus.busy), 32'd1);
    end
    @(posedge clk); #1;
    check("rv_done", 32'(bus.result_valid), 32'd1);
    check("stall_done", 32'(bus.stall), 32'd0);
    check("busy_done", 32'(bus.busy), 32'd0);
    bus.start = keep;
    @(posedge clk); #1;
    check("rv_after", 32'(bus.result_valid), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    check("stall_after", 32'(bus.stall), 32'(keep));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    arst_n        = 1'b0;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rv", 32'(bus.result_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    run_mul(32'd3, 32'd5, 1'b0);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_mul(32'h12345678, 32'h00000100, 1'b0);

    // start held through DONE: one pulse each, second accepted right after DONE
    run_mul(32'd11, 32'd13, 1'b1);
    run_mul(32'hDEADBEEF, 32'h01020304, 1'b0);

    // flush in the 2nd RUN cycle, with start still asserted
    bus.start = 1'b1; bus.operand_a = 32'd100; bus.operand_b = 32'd200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    #1;
    check("stall_flush", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    check("busy_flushed", 32'(bus.busy), 32'd0);
    check("rv_flushed", 32'(bus.result_valid), 32'd0);
    // flush wins over start in IDLE too
    #1;
    check("stall_flush_idle", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    check("busy_flush_idle", 32'(bus.busy), 32'd0);
    bus.flush = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    run_mul(32'd1234, 32'd5678, 1'b0);

    // asynchronous reset in the 3rd RUN cycle
    bus.start = 1'b1; bus.operand_a = 32'd55; bus.operand_b = 32'd66;
    repeat (3) begin @(posedge clk); #1; end
    check("busy_pre_rst", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    arst_n    = 1'b0;
    #1;
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_rv", 32'(bus.result_valid), 32'd0);
    check("arst_result", bus.result, 32'd0);
    #1 arst_n = 1'b1;
    @(posedge clk); #1;
    run_mul(32'd7, 32'd9, 1'b0);

    for (int k = 0; k < 6; k++) run_mul($urandom, $urandom, 1'(k % 2));
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
